// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the LEGv8 ALU control decoder: ALUOp codes, opcode
// patterns and ALU control-line encodings.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_CBZ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_LSL = 11'b11010011011;
  localparam logic [10:0] OP_LSR = 11'b11010011010;

  // I-type opcodes are 10 bits wide; the low instruction bit is don't-care.
  localparam logic [9:0] OPI_ADDI = 10'b1001000100;
  localparam logic [9:0] OPI_SUBI = 10'b1101000100;
  localparam logic [9:0] OPI_ANDI = 10'b1001001000;
  localparam logic [9:0] OPI_ORRI = 10'b1011001000;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LSL   = 4'b0011;
  localparam logic [3:0] ALU_LSR   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef struct packed {
    logic       illegal;
    logic [3:0] ctrl;
  } dec_out_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/opcode decode table producing the ALU control code and
// an illegal flag; unknown codes fall back to a safe ADD.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  input  logic [1:0]  alu_op,
  output logic [3:0]  control,
  output logic        illegal
);

  always_comb begin
    control = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_MEM: control = ALU_ADD;
      ALUOP_CBZ: control = ALU_PASSB;
      ALUOP_R: begin
        case (opcode)
          OP_ADD:  control = ALU_ADD;
          OP_SUB:  control = ALU_SUB;
          OP_AND:  control = ALU_AND;
          OP_ORR:  control = ALU_ORR;
          OP_LSL:  control = ALU_LSL;
          OP_LSR:  control = ALU_LSR;
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_I: begin
        case (opcode[10:1])
          OPI_ADDI: control = ALU_ADD;
          OPI_SUBI: control = ALU_SUB;
          OPI_ANDI: control = ALU_AND;
          OPI_ORRI: control = ALU_ORR;
          default:  illegal = 1'b1;
        endcase
      end
      // X/Z on alu_op lands here in four-state simulation.
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_pipe.sv
// Elastic, DEPTH-stage pipelined ALU control decoder with valid/ready and flush.
// Optional illegal-op counter (err_count/err_clr) enabled by ALU_CTRL_ERRCNT_EN.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int OPC_W  = 11,
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 2
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  inst31_21,
  input  logic [1:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] control_line,
  output logic              illegal
`ifdef ALU_CTRL_ERRCNT_EN
  ,
  input  logic              err_clr,
  output logic [15:0]       err_count
`endif
);

  dec_out_t               dec;
  dec_out_t [DEPTH-1:0]   data_vec;
  logic     [DEPTH-1:0]   valid_vec;
  logic     [DEPTH-1:0]   advance;
  logic                   accept;
  logic                   out_hs;

  alu_ctrl_decode u_decode (
    .opcode  (inst31_21[OPC_W-1 -: 11]),
    .alu_op  (alu_op),
    .control (dec.ctrl),
    .illegal (dec.illegal)
  );

  assign out_hs   = valid_vec[DEPTH-1] & out_ready;
  assign in_ready = ~valid_vec[0] | advance[0];
  assign accept   = in_valid & in_ready & ~flush;

  // Ready ripples back from the consumer so a full pipeline streams bubble-free.
  always_comb begin
    advance = '0;
    advance[DEPTH-1] = out_hs;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      advance[k] = valid_vec[k] & (~valid_vec[k+1] | advance[k+1]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : stage_g
      logic     valid_reg;
      dec_out_t data_reg;
      logic     src_valid;
      dec_out_t src_data;

      if (gi == 0) begin : g_src_in
        assign src_valid = accept;
        assign src_data  = dec;
      end else begin : g_src_prev
        assign src_valid = valid_vec[gi-1];
        assign src_data  = data_vec[gi-1];
      end

      // Data only reloads with a valid source so the last stage holds while idle.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (flush) begin
          valid_reg <= 1'b0;
        end else if (~valid_reg | advance[gi]) begin
          valid_reg <= src_valid;
          if (src_valid) begin
            data_reg <= src_data;
          end
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign data_vec[gi]  = data_reg;
    end
  endgenerate

  assign out_valid    = valid_vec[DEPTH-1];
  assign control_line = CTRL_W'(data_vec[DEPTH-1].ctrl);
  assign illegal      = data_vec[DEPTH-1].illegal;

`ifdef ALU_CTRL_ERRCNT_EN
  logic [15:0] err_count_reg;

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_count_reg <= 16'h0000;
    end else if (out_hs && illegal && (err_count_reg != 16'hFFFF)) begin
      err_count_reg <= err_count_reg + 16'h0001;
    end
  end

  assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// Scoreboard bench for alu_control_pipe: stimulus pushes expected decodes, a
// negedge monitor pops them on each output handshake. ALU_CTRL_ERRCNT_EN optional.
module tb_alu_control_pipe;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] inst31_21;
  logic [1:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  control_line;
  logic        illegal;
`ifdef ALU_CTRL_ERRCNT_EN
  logic        err_clr;
  logic [15:0] err_count;
`endif

  always #5 clk = ~clk;

  alu_control_pipe #(.OPC_W(11), .CTRL_W(4), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inst31_21    (inst31_21),
    .alu_op       (alu_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .control_line (control_line),
    .illegal      (illegal)
`ifdef ALU_CTRL_ERRCNT_EN
    ,
    .err_clr      (err_clr),
    .err_count    (err_count)
`endif
  );

  typedef struct {
    logic [3:0] ctrl;
    logic       ill;
    int         acc_cyc;
    bit         lat_chk;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [10:0] inst;
    logic [3:0]  ctrl;
    logic        ill;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs [15];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one pop per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_output: got ctrl %b illegal %b, expected no output", control_line, illegal);
      end else begin
        mon_e = sb.pop_front();
        $display("out: ctrl=%b illegal=%b (exp %b/%b) cycle %0d", control_line, illegal,
                 mon_e.ctrl, mon_e.ill, cyc);
        check("out_ctrl", 32'(control_line), 32'(mon_e.ctrl));
        check("out_illegal", 32'(illegal), 32'(mon_e.ill));
        if (mon_e.lat_chk) check("latency", 32'(cyc - mon_e.acc_cyc), DEPTH);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v);
    int   t;
    exp_t e;
    t = 0;
    alu_op    = v.op;
    inst31_21 = v.inst;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0, expected 1 within 50 cycles");
    end else begin
      e.ctrl    = v.ctrl;
      e.ill     = v.ill;
      e.acc_cyc = cyc;
      e.lat_chk = out_ready;
      sb.push_back(e);
      $display("in: alu_op=%b inst=%b cycle %0d", v.op, v.inst, cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending ops, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bad;
    //          alu_op  inst              ctrl     illegal
    vecs[0]  = '{2'b10, 11'b11001011000, 4'b0110, 1'b0}; // SUB
    vecs[1]  = '{2'b10, 11'b10101010000, 4'b0001, 1'b0}; // ORR
    vecs[2]  = '{2'b11, 11'b10010010001, 4'b0000, 1'b0}; // ANDI, bit0 set
    vecs[3]  = '{2'b10, 11'b10001011000, 4'b0010, 1'b0}; // ADD
    vecs[4]  = '{2'b10, 11'b10001010000, 4'b0000, 1'b0}; // AND
    vecs[5]  = '{2'b10, 11'b11010011011, 4'b0011, 1'b0}; // LSL
    vecs[6]  = '{2'b10, 11'b11010011010, 4'b0100, 1'b0}; // LSR
    vecs[7]  = '{2'b11, 11'b10010001000, 4'b0010, 1'b0}; // ADDI
    vecs[8]  = '{2'b11, 11'b11010001001, 4'b0110, 1'b0}; // SUBI
    vecs[9]  = '{2'b11, 11'b10110010000, 4'b0001, 1'b0}; // ORRI
    vecs[10] = '{2'b10, 11'b11111111111, 4'b0010, 1'b1}; // bad R
    vecs[11] = '{2'b00, 11'b11111111111, 4'b0010, 1'b0}; // LDUR/STUR
    vecs[12] = '{2'b01, 11'b10110100000, 4'b0111, 1'b0}; // CBZ
    vecs[13] = '{2'b10, 11'b10001011001, 4'b0010, 1'b1}; // ADD off by one bit
    vecs[14] = '{2'b11, 11'b00000000000, 4'b0010, 1'b1}; // bad I
    bad = vecs[10];

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = 2'b00;
    inst31_21 = '0;
`ifdef ALU_CTRL_ERRCNT_EN
    err_clr   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_ctrl", 32'(control_line), 0);
    check("reset_illegal", 32'(illegal), 0);
    check("reset_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Back-to-back stream through the whole table.
    for (int i = 0; i < 15; i++) send(vecs[i]);
    drain();

    // Back-pressure: two ops fill the pipe, the third must wait.
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[1]);
    alu_op    = vecs[5].op;
    inst31_21 = vecs[5].inst;
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_hold_ctrl", 32'(control_line), 32'(4'b0110));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(vecs[5]);
    drain();

    // Flush a full pipeline while a new op is offered.
    out_ready = 1'b0;
    send(vecs[3]);
    send(vecs[4]);
    alu_op    = vecs[6].op;
    inst31_21 = vecs[6].inst;
    in_valid  = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(vecs[12]);
    drain();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;

`ifdef ALU_CTRL_ERRCNT_EN
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("errcnt_cleared", 32'(err_count), 0);
    @(posedge clk);
    #1;
    repeat (5) send(bad);
    send(vecs[0]);
    drain();
    @(negedge clk);
    check("errcnt_five", 32'(err_count), 5);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    send(bad);
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    err_clr = 1'b0;
    drain();
    @(negedge clk);
    check("errcnt_clr_wins", 32'(err_count), 0);
    @(posedge clk);
    #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
